// File: rtl/calc_pkg.sv
// Shared key codes, operator encodings and the keypad position map.
package calc_pkg;

    typedef enum logic [4:0] {
        K0     = 5'd0,  K1 = 5'd1, K2 = 5'd2, K3 = 5'd3, K4 = 5'd4,
        K5     = 5'd5,  K6 = 5'd6, K7 = 5'd7, K8 = 5'd8, K9 = 5'd9,
        K_ADD  = 5'd10,
        K_SUB  = 5'd11,
        K_MUL  = 5'd12,
        K_EQ   = 5'd13,
        K_CLR  = 5'd14,
        K_NOP  = 5'd15,   // the unused (r3,c3) position: a real key with no action
        K_NONE = 5'd16,
        K_MULTI= 5'd17
    } key_code_t;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b100;

    // Physical (row,col) to key code.
    function automatic key_code_t key_map(input logic [1:0] row, input logic [1:0] col);
        key_code_t k;
        case ({row, col})
            4'd0:    k = K1;
            4'd1:    k = K2;
            4'd2:    k = K3;
            4'd3:    k = K_ADD;
            4'd4:    k = K4;
            4'd5:    k = K5;
            4'd6:    k = K6;
            4'd7:    k = K_SUB;
            4'd8:    k = K7;
            4'd9:    k = K8;
            4'd10:   k = K9;
            4'd11:   k = K_MUL;
            4'd12:   k = K_CLR;
            4'd13:   k = K0;
            4'd14:   k = K_EQ;
            default: k = K_NOP;
        endcase
        return k;
    endfunction

    // True for a single-key scan result; NONE and MULTI both count as "no key".
    function automatic logic is_key(input key_code_t k);
        return k < K_NONE;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner: drives one column at a time, synchronises the rows and
// folds the four column samples into one key_code_t per full scan.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       scan_done,
    output key_code_t  scan_code
);

    localparam int DW = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);

    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_s1, row_s2;
    logic [1:0]    acc_hits;   // keys seen so far this scan, saturating at 2
    key_code_t     acc_code;
    logic          sample;
    logic [2:0]    pop;
    logic [1:0]    row_sel;
    logic [2:0]    hit_sum;
    logic [1:0]    cur_hits;
    key_code_t     cur_code;

    assign sample    = (div_cnt == DW'(SCAN_DIV - 1));
    assign col_out   = 4'b0001 << col_idx;
    assign scan_done = sample && (col_idx == 2'd3);

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (RST) begin
            row_s1 <= '0;
            row_s2 <= '0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    // Column dwell counter; the column advances after its last (sampling) cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            div_cnt <= '0;
            col_idx <= '0;
        end else if (sample) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Merge this column's rows into the running scan result.
    always_comb begin
        pop     = '0;
        row_sel = '0;
        for (int r = 0; r < 4; r++) begin
            if (row_s2[r]) begin
                pop     = pop + 3'd1;
                row_sel = 2'(r);
            end
        end
        hit_sum  = {1'b0, acc_hits} + pop;
        cur_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        cur_code = (pop == 3'd1) ? key_map(row_sel, col_idx) : acc_code;
        if (cur_hits == 2'd0)      scan_code = K_NONE;
        else if (cur_hits == 2'd1) scan_code = cur_code;
        else                       scan_code = K_MULTI;
    end

    // Per-scan accumulator, cleared when the column-3 sample completes a scan.
    always_ff @(posedge clk) begin
        if (RST || scan_done) begin
            acc_hits <= '0;
            acc_code <= K_NONE;
        end else if (sample) begin
            acc_hits <= cur_hits;
            acc_code <= cur_code;
        end
    end

endmodule

// File: rtl/keypad_ctrl.sv
// Keypad front end: debounce FSM over full-scan results, key decode into
// digit/operator/equal/clear strobes, and the post-equal operator hold timer.
module keypad_ctrl
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int OP_HOLD        = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_input
);

    localparam int CW = ($clog2(DEBOUNCE_SCANS + 1) < 1) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
    localparam int HW = ($clog2(OP_HOLD + 1) < 1) ? 1 : $clog2(OP_HOLD + 1);

    typedef enum logic [1:0] {IDLE, DEBNC, PRESSED, RELEASE} state_t;

    state_t        state, state_nx;
    key_code_t     cand, cand_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          emit;
    logic          scan_done;
    key_code_t     scan_code;
    logic          hold_pend;
    logic [HW-1:0] hold_cnt;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk       (clk),
        .RST       (RST),
        .row_in    (row_in),
        .col_out   (col_out),
        .scan_done (scan_done),
        .scan_code (scan_code)
    );

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
            cand  <= K_NONE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            cnt   <= cnt_nx;
        end
    end

    // Debounce next-state: steps once per completed scan; emit marks acceptance.
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        emit     = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: if (is_key(scan_code)) begin
                    cand_nx = scan_code;
                    cnt_nx  = CW'(1);
                    if (DEBOUNCE_SCANS <= 1) begin
                        state_nx = PRESSED;
                        emit     = 1'b1;
                    end else begin
                        state_nx = DEBNC;
                    end
                end
                DEBNC: if (scan_code == cand) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt_nx >= CW'(DEBOUNCE_SCANS)) begin
                        state_nx = PRESSED;
                        emit     = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
                PRESSED: if (!is_key(scan_code)) begin
                    state_nx = RELEASE;
                    cnt_nx   = CW'(1);
                end
                RELEASE: if (!is_key(scan_code)) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt_nx >= CW'(DEBOUNCE_SCANS)) state_nx = IDLE;
                end else begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Key decode, one-cycle strobes and the operator latch with its hold timer.
    // The hold counter lets operator_input survive OP_HOLD cycles past the
    // equal pulse so the consumer can still sample it, then drops to none.
    always_ff @(posedge clk) begin
        if (RST) begin
            keypad_input   <= '0;
            read_input     <= 1'b0;
            operator_input <= OP_NONE;
            equal_input    <= 1'b0;
            clear_input    <= 1'b0;
            hold_pend      <= 1'b0;
            hold_cnt       <= '0;
        end else begin
            read_input  <= 1'b0;
            equal_input <= 1'b0;
            clear_input <= 1'b0;
            if (hold_pend) begin
                if (hold_cnt == '0) begin
                    operator_input <= OP_NONE;
                    hold_pend      <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - HW'(1);
                end
            end
            if (emit) begin
                if (cand_nx <= K9) begin
                    keypad_input <= 4'(cand_nx);
                    read_input   <= 1'b1;
                end else begin
                    case (cand_nx)
                        K_ADD: begin operator_input <= OP_ADD; hold_pend <= 1'b0; end
                        K_SUB: begin operator_input <= OP_SUB; hold_pend <= 1'b0; end
                        K_MUL: begin operator_input <= OP_MUL; hold_pend <= 1'b0; end
                        K_EQ: if (operator_input != OP_NONE) begin
                            equal_input <= 1'b1;
                            hold_pend   <= 1'b1;
                            hold_cnt    <= HW'(OP_HOLD);
                        end
                        K_CLR: begin
                            clear_input    <= 1'b1;
                            operator_input <= OP_NONE;
                            hold_pend      <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_ctrl.sv
// Directed bench for keypad_ctrl: keypad modelled as a 16-bit pressed-key mask
// (bit r*4+c) feeding rows from the driven column.
module tb_keypad_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  keypad_input;
    logic        read_input;
    logic [2:0]  operator_input;
    logic        equal_input;
    logic        clear_input;
    logic [15:0] pressed;

    int n_chk = 0, n_pass = 0;
    int rd_cnt = 0, eq_cnt = 0, clr_cnt = 0;
    int last_dig = 0;

    keypad_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .OP_HOLD(2)) dut (
        .clk            (clk),
        .RST            (RST),
        .row_in         (row_in),
        .col_out        (col_out),
        .keypad_input   (keypad_input),
        .read_input     (read_input),
        .operator_input (operator_input),
        .equal_input    (equal_input),
        .clear_input    (clear_input)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key connects its column drive to its row.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 4; r++) row_in[r] = |(pressed[r*4 +: 4] & col_out);
    end

    // Strobe monitor.
    always @(negedge clk) begin
        if (read_input) begin
            rd_cnt   <= rd_cnt + 1;
            last_dig <= int'(keypad_input);
        end
        if (equal_input) eq_cnt  <= eq_cnt + 1;
        if (clear_input) clr_cnt <= clr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] mask;
        int          rd;
        int          eq;
        int          clr;
        logic [2:0]  op;
        logic [3:0]  dig;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic clr_counts();
        rd_cnt = 0; eq_cnt = 0; clr_cnt = 0;
    endtask

    // Return at the negedge in the first cycle of column 0.
    task automatic align();
        logic [3:0] prev;
        logic       found;
        prev  = col_out;
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            if (prev == 4'b1000 && col_out == 4'b0001) found = 1'b1;
            prev = col_out;
        end
        chk("align to scan start", int'(found), 1);
    endtask

    // Hold a key mask for n whole scans (16 clk each).
    task automatic seg(input logic [15:0] m, input int n);
        pressed = m;
        repeat (16 * n) @(negedge clk);
    endtask

    initial begin
        int  first_k;
        bit  found;

        tbl[0]  = '{16'h4000, 0, 0, 0, 3'b000, 4'd1};  // '=' with no op: ignored
        tbl[1]  = '{16'h0060, 0, 0, 0, 3'b000, 4'd1};  // '5'+'6': MULTI
        tbl[2]  = '{16'h0800, 0, 0, 0, 3'b100, 4'd1};  // '*'
        tbl[3]  = '{16'h0080, 0, 0, 0, 3'b010, 4'd1};  // '-' overwrites
        tbl[4]  = '{16'h1000, 0, 0, 1, 3'b000, 4'd1};  // CLR
        tbl[5]  = '{16'h0200, 1, 0, 0, 3'b000, 4'd8};  // '8'
        tbl[6]  = '{16'h2000, 1, 0, 0, 3'b000, 4'd0};  // '0'
        tbl[7]  = '{16'h8000, 0, 0, 0, 3'b000, 4'd0};  // unused key
        tbl[8]  = '{16'h0008, 0, 0, 0, 3'b001, 4'd0};  // '+'
        tbl[9]  = '{16'h0004, 1, 0, 0, 3'b001, 4'd3};  // '3'
        tbl[10] = '{16'h4000, 0, 1, 0, 3'b000, 4'd3};  // '=' then op cleared

        pressed = '0;
        RST     = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset col_out", int'(col_out), 1);
        chk("reset keypad_input", int'(keypad_input), 0);
        chk("reset read_input", int'(read_input), 0);
        chk("reset operator_input", int'(operator_input), 0);
        chk("reset equal_input", int'(equal_input), 0);
        chk("reset clear_input", int'(clear_input), 0);
        RST = 1'b0;

        // '7' held 5 scans: column sweep, exact accept latency, single pulse.
        align();
        clr_counts();
        pressed = 16'h0100;
        first_k = -1;
        for (int k = 0; k < 80; k++) begin
            if (k < 16 && (k % 4) == 0) chk($sformatf("col_out k=%0d", k), int'(col_out), 1 << (k / 4));
            if (read_input && first_k < 0) begin
                first_k = k;
                chk("key7 keypad_input at pulse", int'(keypad_input), 7);
            end
            @(negedge clk);
        end
        chk("key7 read latency", first_k, 32);
        seg(16'h0, 3);
        chk("key7 read count", rd_cnt, 1);
        chk("key7 digit", last_dig, 7);

        // One-scan glitch on '9'.
        clr_counts();
        seg(16'h0400, 1);
        seg(16'h0, 3);
        chk("glitch9 read count", rd_cnt, 0);

        // '1' with a bounce on release: NONE, KEY, NONE, NONE.
        clr_counts();
        seg(16'h0001, 4);
        seg(16'h0, 1);
        seg(16'h0001, 1);
        seg(16'h0, 3);
        chk("bounce1 read count", rd_cnt, 1);
        chk("bounce1 keypad_input", int'(keypad_input), 1);

        // Table vectors.
        for (int i = 0; i < 11; i++) begin
            clr_counts();
            seg(tbl[i].mask, 5);
            seg(16'h0, 3);
            chk($sformatf("v%0d read count", i), rd_cnt, tbl[i].rd);
            chk($sformatf("v%0d equal count", i), eq_cnt, tbl[i].eq);
            chk($sformatf("v%0d clear count", i), clr_cnt, tbl[i].clr);
            chk($sformatf("v%0d operator_input", i), int'(operator_input), int'(tbl[i].op));
            chk($sformatf("v%0d keypad_input", i), int'(keypad_input), int'(tbl[i].dig));
        end

        // Operator hold window after '='.
        seg(16'h0800, 5);
        seg(16'h0, 3);
        chk("hold pre op", int'(operator_input), 4);
        pressed = 16'h4000;
        found   = 1'b0;
        for (int n = 0; n < 96 && !found; n++) begin
            @(negedge clk);
            if (equal_input) found = 1'b1;
        end
        chk("hold equal seen", int'(found), 1);
        chk("hold op at e", int'(operator_input), 4);
        @(negedge clk);
        chk("hold equal width", int'(equal_input), 0);
        @(negedge clk);
        chk("hold op at e+2", int'(operator_input), 4);
        @(negedge clk);
        chk("hold op at e+3", int'(operator_input), 0);
        pressed = '0;
        repeat (48) @(negedge clk);

        // RST during debounce of '4', with an operator latched beforehand.
        seg(16'h0800, 5);
        seg(16'h0, 3);
        align();
        clr_counts();
        seg(16'h0010, 1);
        repeat (8) @(negedge clk);
        RST     = 1'b1;
        pressed = '0;
        @(negedge clk);
        chk("mid reset col_out", int'(col_out), 1);
        chk("mid reset operator_input", int'(operator_input), 0);
        chk("mid reset keypad_input", int'(keypad_input), 0);
        chk("mid reset read_input", int'(read_input), 0);
        RST = 1'b0;
        repeat (64) @(negedge clk);
        chk("mid reset no read after", rd_cnt, 0);
        chk("mid reset no equal after", eq_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
